// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and decode.
// The master side is the fetch unit. The slave side is its environment:
// the memory, decode and redirect source.
interface instruction_fetch_unit_if;
  // Instruction memory read port
  logic [31:0] imem_addr_out;
  logic [31:0] imem_data_in;

  // Control from decode and the branch unit
  logic        stall_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;

  // Instruction/PC pair delivered to decode
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;

  modport master (
    output imem_addr_out,
    input  imem_data_in,
    input  stall_in,
    input  redirect_valid_in,
    input  redirect_pc_in,
    output instr_out,
    output pc_out,
    output instr_valid_out
  );

  modport slave (
    input  imem_addr_out,
    output imem_data_in,
    output stall_in,
    output redirect_valid_in,
    output redirect_pc_in,
    input  instr_out,
    input  pc_out,
    input  instr_valid_out
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage in front of a synchronous-read instruction memory.
// One address is issued per cycle. The response arrives the cycle after issue
// and is paired with its PC. A one-entry hold buffer keeps a stalled item
// stable while decode is not ready. A redirect flushes both the in-flight
// response and the hold buffer, and it issues the target in the same edge.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_unit_if.master   bus
);

  // Architectural state
  logic [31:0] fetch_pc_q,   fetch_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q,    resp_pc_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q,    hold_pc_d;

  // Combinational helpers
  logic [31:0] redirect_tgt;
  logic [31:0] issue_addr;
  logic        issue;

  // Pick the address presented to memory this cycle. A redirect overrides the
  // sequential PC so that the target read starts at this very edge.
  always_comb begin
    redirect_tgt = bus.redirect_pc_in & 32'hFFFF_FFFC;
    issue_addr   = bus.redirect_valid_in ? redirect_tgt : fetch_pc_q;
    // A stall freezes the front end unless a redirect forces a new stream
    issue        = bus.redirect_valid_in | ~bus.stall_in;
  end

  // While reset is held, drive the reset address. This keeps memory and decode
  // clean even before the first reset edge has cleared the flops.
  assign bus.imem_addr_out = rst_n ? issue_addr : RESET_PC;

  // The hold buffer takes precedence because it carries the older item. The
  // live memory response is only shown when nothing is parked.
  assign bus.instr_out       = hold_valid_q ? hold_instr_q : bus.imem_data_in;
  assign bus.pc_out          = hold_valid_q ? hold_pc_q    : resp_pc_q;
  assign bus.instr_valid_out = rst_n & (hold_valid_q | resp_valid_q) &
                               ~bus.redirect_valid_in;

  // Next-state computation for issue tracking and the hold buffer
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_valid_d = 1'b0;
    resp_pc_d    = resp_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;

    if (issue) begin
      resp_valid_d = 1'b1;
      resp_pc_d    = issue_addr;
      // 32-bit wrap is intentional: 0xFFFF_FFFC is followed by 0x0000_0000
      fetch_pc_d   = issue_addr + 32'd4;
    end

    if (bus.redirect_valid_in) begin
      // Anything older than the target belongs to the wrong path
      hold_valid_d = 1'b0;
    end else if (bus.stall_in) begin
      // Park the response before it disappears. The memory output is not held
      // because the next edge may read another address.
      if (resp_valid_q && !hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_instr_d = bus.imem_data_in;
        hold_pc_d    = resp_pc_q;
      end
    end else begin
      // Decode consumes whatever is presented, so the buffer is free again
      hold_valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= 32'h0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule
